// File: rtl/shared_resource_arbiter_n.sv
// rtl/shared_resource_arbiter_n.sv - N-channel round-robin arbiter in front of a shared fixed-latency pipeline
// Per-channel hold registers, credit-guarded output FIFOs and per-channel flush.
module shared_resource_arbiter_n #(
  parameter int N_CH  = 2,
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int MODE  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_flush,
  output logic [N_CH-1:0]       out_stall,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       in_stall
);

  localparam int FDEPTH = DEPTH + 2;
  localparam int TAG_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PTR_W  = $clog2(FDEPTH);
  localparam int CNT_W  = $clog2(FDEPTH + 1);

  logic [N_CH-1:0]  hold_valid;
  logic [WIDTH-1:0] hold_data [N_CH];
  logic [CNT_W-1:0] credit [N_CH];
  logic [TAG_W-1:0] rr_ptr;

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [TAG_W-1:0] stage_tag [DEPTH];

  logic [WIDTH-1:0] fifo_mem [N_CH][FDEPTH];
  logic [PTR_W-1:0] fifo_rd [N_CH];
  logic [PTR_W-1:0] fifo_wr [N_CH];
  logic [CNT_W-1:0] fifo_cnt [N_CH];

  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  grant;
  logic [N_CH-1:0]  accept;
  logic [N_CH-1:0]  pop;
  logic [N_CH-1:0]  fifo_wr_en;
  logic             grant_any;
  logic [TAG_W-1:0] grant_idx;

  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] d);
    if (MODE == 1) return d + WIDTH'(1);
    else if (MODE == 2) return ~d;
    else return d;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == FDEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      eligible[i]   = hold_valid[i] && (credit[i] < CNT_W'(FDEPTH)) && !in_flush[i];
      out_valid[i]  = (fifo_cnt[i] != '0) && !in_flush[i];
      pop[i]        = out_valid[i] && !in_stall[i];
      fifo_wr_en[i] = stage_valid[DEPTH-1] && (stage_tag[DEPTH-1] == TAG_W'(i)) && !in_flush[i];
      // Head is masked while empty so reset and flush present zero data.
      if (fifo_cnt[i] != '0) out_data[i*WIDTH +: WIDTH] = fifo_mem[i][fifo_rd[i]];
    end
    out_stall = hold_valid & ~grant;
    accept    = in_valid & ~out_stall & ~in_flush;
  end

  always_comb begin : arb
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!grant_any) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (eligible[idx]) begin
          grant[idx] = 1'b1;
          grant_any  = 1'b1;
          grant_idx  = TAG_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid  <= '0;
      stage_valid <= '0;
      rr_ptr      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        credit[i]   <= '0;
        fifo_rd[i]  <= '0;
        fifo_wr[i]  <= '0;
        fifo_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (in_flush[i])    hold_valid[i] <= 1'b0;
        else if (accept[i]) hold_valid[i] <= 1'b1;
        else if (grant[i])  hold_valid[i] <= 1'b0;
        if (accept[i]) hold_data[i] <= in_data[i*WIDTH +: WIDTH];

        if (in_flush[i])              credit[i] <= '0;
        else if (grant[i] && !pop[i]) credit[i] <= credit[i] + CNT_W'(1);
        else if (!grant[i] && pop[i]) credit[i] <= credit[i] - CNT_W'(1);

        if (in_flush[i]) begin
          fifo_rd[i]  <= '0;
          fifo_wr[i]  <= '0;
          fifo_cnt[i] <= '0;
        end else begin
          if (fifo_wr_en[i]) begin
            fifo_mem[i][fifo_wr[i]] <= stage_data[DEPTH-1];
            fifo_wr[i]              <= ptr_inc(fifo_wr[i]);
          end
          if (pop[i]) fifo_rd[i] <= ptr_inc(fifo_rd[i]);
          if (fifo_wr_en[i] && !pop[i])      fifo_cnt[i] <= fifo_cnt[i] + CNT_W'(1);
          else if (!fifo_wr_en[i] && pop[i]) fifo_cnt[i] <= fifo_cnt[i] - CNT_W'(1);
        end
      end

      // Stages never stall; a flushed channel's items are dropped as they advance.
      stage_valid[0] <= grant_any;
      stage_data[0]  <= apply_op(hold_data[grant_idx]);
      stage_tag[0]   <= grant_idx;
      for (int k = 1; k < DEPTH; k++) begin
        stage_valid[k] <= stage_valid[k-1] && !in_flush[stage_tag[k-1]];
        stage_data[k]  <= stage_data[k-1];
        stage_tag[k]   <= stage_tag[k-1];
      end

      if (grant_any) rr_ptr <= (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + TAG_W'(1);
    end
  end

endmodule

// File: tb/tb_shared_resource_arbiter_n.sv
// tb/tb_shared_resource_arbiter_n.sv - scoreboard bench for shared_resource_arbiter_n
module tb_shared_resource_arbiter_n;
  localparam int N_CH = 2, WIDTH = 32, DEPTH = 3, MODE = 1, LAT = DEPTH + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [1:0]  in_valid = '0, in_flush = '0, in_stall = '0;
  logic [1:0]  out_stall, out_valid;
  logic [63:0] out_data;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          checks = 0, errors = 0, cyc = 0, pop_cnt = 0;
  bit          lat_chk = 1'b0;
  logic [1:0]  stream_en = '0, acc_last = '0;
  logic [31:0] sdata [2];

  shared_resource_arbiter_n #(.N_CH(N_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(MODE)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_flush(in_flush),
    .out_stall(out_stall), .out_data(out_data), .out_valid(out_valid), .in_stall(in_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Accepted items enter the per-channel expected queues as data+1.
  always @(negedge clk) begin
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
      acc_last <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (in_flush[ch]) begin
          if (ch == 0) exp_q0.delete(); else exp_q1.delete();
        end else if (in_valid[ch] && !out_stall[ch]) begin
          if (ch == 0) exp_q0.push_back('{in_data[ch*32 +: 32] + 32'd1, cyc + LAT, lat_chk});
          else         exp_q1.push_back('{in_data[ch*32 +: 32] + 32'd1, cyc + LAT, lat_chk});
        end
      end
      acc_last <= in_valid & ~out_stall & ~in_flush;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (out_valid[ch] && !in_stall[ch]) begin
          exp_t e;
          pop_cnt++;
          if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop ch=%0d cyc=%0d actual=%0h required=none", ch, cyc, out_data[ch*32 +: 32]);
          end else begin
            e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk(ch == 0 ? "data_ch0" : "data_ch1", 64'(out_data[ch*32 +: 32]), 64'(e.data));
            if (e.chk) chk("latency", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      if (stream_en[ch]) begin
        if (acc_last[ch]) sdata[ch] = sdata[ch] + 32'd1;
        in_valid[ch] = 1'b1;
        in_data[ch*32 +: 32] = sdata[ch];
      end else begin
        in_valid[ch] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    stream_en = '0;
    in_flush  = '0;
    in_stall  = '0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain_check(input int n);
    for (int k = 0; k < n; k++) tick();
    @(negedge clk);
    chk("drain_q0", 64'(exp_q0.size()), 64'd0);
    chk("drain_q1", 64'(exp_q1.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, snap;
    // Reset with random inputs
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      in_data  = {$urandom, $urandom};
      in_valid = 2'($urandom);
      in_flush = 2'($urandom);
      in_stall = 2'($urandom);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_stall", 64'(out_stall), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = '0; in_flush = '0; in_stall = '0; in_data = '0;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_out_stall", 64'(out_stall), 64'd0);
    chk("post_rst_out_data", out_data, 64'd0);

    // Latency and increment wrap on ch0
    do_reset();
    lat_chk = 1'b1;
    tick();
    in_valid[0] = 1'b1; in_data[31:0] = 32'h10;
    c0 = cyc;
    tick();
    in_valid[0] = 1'b1; in_data[31:0] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("lat_second_accept", 64'(out_stall[0]), 64'd0);
    tick();
    @(negedge clk);
    lat_chk = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      if (cyc == c0 + 4) chk("lat_not_early", 64'(out_valid[0]), 64'd0);
    end
    drain_check(4);

    // Round-robin alternation with both channels streaming
    do_reset();
    sdata[0] = 32'h100; sdata[1] = 32'h200;
    stream_en = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick();
      @(negedge clk);
      if (k >= 1) chk("rr_out_stall", 64'(out_stall), (k % 2 == 1) ? 64'd2 : 64'd1);
    end
    stream_en = '0;
    drain_check(12);

    // Isolation: ch0 consumer stalled forever, ch1 keeps flowing
    do_reset();
    sdata[0] = 32'h300; sdata[1] = 32'h400;
    in_stall = 2'b01;
    stream_en = 2'b11;
    for (int k = 0; k < 28; k++) begin
      tick();
      @(negedge clk);
      if (k >= 10) chk("iso_out_stall", 64'(out_stall), 64'd1);
      if (k >= 14) chk("iso_ch1_valid", 64'(out_valid[1]), 64'd1);
      if (k == 12) chk("iso_credit0_full", 64'(dut.credit[0]), 64'd5);
    end
    stream_en = '0;
    in_stall = '0;
    drain_check(16);

    // Flush ch1 with items in hold, stages and FIFO
    do_reset();
    sdata[0] = 32'h500; sdata[1] = 32'h600;
    in_stall = 2'b10;
    stream_en = 2'b11;
    for (int k = 0; k < 8; k++) tick();
    stream_en[1] = 1'b0;
    tick();
    in_flush = 2'b10;
    @(negedge clk);
    chk("flush_ch1_valid", 64'(out_valid[1]), 64'd0);
    tick();
    in_flush = '0; in_stall = '0;
    @(negedge clk);
    chk("flush_credit1", 64'(dut.credit[1]), 64'd0);
    for (int k = 0; k < 7; k++) begin
      tick();
      @(negedge clk);
      chk("flush_no_stale", 64'(out_valid[1]), 64'd0);
    end
    stream_en = '0;
    for (int k = 0; k < 10; k++) tick();
    lat_chk = 1'b1;
    tick();
    in_valid[1] = 1'b1; in_data[63:32] = 32'h7777;
    @(negedge clk);
    lat_chk = 1'b0;
    drain_check(8);

    // Reset mid-operation with both FIFOs holding items
    do_reset();
    sdata[0] = 32'h800; sdata[1] = 32'h900;
    in_stall = 2'b11;
    stream_en = 2'b11;
    for (int k = 0; k < 12; k++) tick();
    @(negedge clk);
    chk("midrst_fifos_full", 64'(out_valid), 64'd3);
    stream_en = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_stall = '0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    snap = pop_cnt;
    for (int k = 0; k < 15; k++) tick();
    @(negedge clk);
    chk("midrst_no_stale", 64'(pop_cnt), 64'(snap));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
